// File: rtl/renderer_pkg.sv
// renderer_pkg: shared pixel types, raster defaults and the 24->12 bit colour pack
package renderer_pkg;
  localparam int DEF_START_X       = 390;
  localparam int DEF_START_Y       = 390;
  localparam int DEF_END_X         = 634;
  localparam int DEF_END_Y         = 765;
  localparam int DEF_REGION_DIVIDE = 530;
  localparam int DEF_COL_SHIFT     = 2;
  localparam int DEF_ADDR_W        = 17;
  typedef logic [23:0] rgb24_t;
  typedef logic [11:0] rgb12_t;
  typedef struct packed {
    rgb24_t      data;
    logic [10:0] h;
    logic [9:0]  v;
  } beat_t;
  function automatic rgb12_t pack_rgb12(input rgb24_t c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: single-entry holding register for a beat accepted while the pipeline is held
module axis_skid_buffer #(
  parameter int W = 45
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q;
  logic [W-1:0] data_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= push_i | (full_q & ~pop_i);
      if (push_i) data_q <= data_i;
    end
  end
  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer: AXIS pixel sink that corrects, bounds-checks and writes 12-bit pixels to the frame buffer
module pixel_stream_writer
  import renderer_pkg::*;
#(
  parameter int START_X       = DEF_START_X,
  parameter int START_Y       = DEF_START_Y,
  parameter int END_X         = DEF_END_X,
  parameter int END_Y         = DEF_END_Y,
  parameter int REGION_DIVIDE = DEF_REGION_DIVIDE,
  parameter int COL_SHIFT     = DEF_COL_SHIFT,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hold_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic [7:0]        drop_count
);
  localparam int WIDTH  = END_X - START_X;
  localparam int HEIGHT = END_Y - START_Y;
  logic              tready_q, accept, skid_full;
  beat_t             in_beat, skid_beat, s1_beat;
  logic              s1_vld_d, s1_inb_d, s1_last_d;
  logic [11:0]       x_rel_d, y_rel_d;
  logic              s1_vld_q, s1_inb_q, s1_last_q;
  logic [11:0]       x_rel_q, y_rel_q;
  rgb12_t            s1_pix_q, wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_en_q, frame_done_q;
  logic [7:0]        frame_count_q, drop_count_q;
  assign in_beat = {pixel_axis_tdata, hcount_in, vcount_in};
  assign accept  = pixel_axis_tvalid & tready_q;
  // a beat caught by the falling tready edge parks here and always drains next, ahead of new input
  axis_skid_buffer #(.W($bits(beat_t))) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (accept & hold_in),
    .pop_i   (skid_full),
    .data_i  (in_beat),
    .full_o  (skid_full),
    .data_o  (skid_beat)
  );
  always_comb begin
    s1_beat   = skid_full ? skid_beat : in_beat;
    s1_vld_d  = skid_full | (accept & ~hold_in);
    x_rel_d   = 12'(s1_beat.h) - 12'(START_X)
              - (s1_beat.v < 10'(REGION_DIVIDE) ? 12'(COL_SHIFT) : 12'd0);
    y_rel_d   = 12'(s1_beat.v) - 12'(START_Y);
    s1_inb_d  = !x_rel_d[11] && x_rel_d < 12'(WIDTH) && !y_rel_d[11] && y_rel_d < 12'(HEIGHT);
    s1_last_d = s1_beat.h == 11'(END_X - 1) && s1_beat.v == 10'(END_Y - 1);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_q      <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_inb_q      <= 1'b0;
      s1_last_q     <= 1'b0;
      x_rel_q       <= '0;
      y_rel_q       <= '0;
      s1_pix_q      <= '0;
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      tready_q     <= ~hold_in & ~skid_full;
      s1_vld_q     <= s1_vld_d;
      s1_inb_q     <= s1_inb_d;
      s1_last_q    <= s1_last_d;
      x_rel_q      <= x_rel_d;
      y_rel_q      <= y_rel_d;
      s1_pix_q     <= pack_rgb12(s1_beat.data);
      wr_en_q      <= s1_vld_q & s1_inb_q;
      frame_done_q <= s1_vld_q & s1_inb_q & s1_last_q;
      if (s1_vld_q & s1_inb_q) begin
        wr_addr_q <= ADDR_W'(y_rel_q) * ADDR_W'(WIDTH) + ADDR_W'(x_rel_q);
        wr_data_q <= s1_pix_q;
      end
      if (s1_vld_q & ~s1_inb_q & ~&drop_count_q) drop_count_q <= drop_count_q + 8'd1;
      if (frame_done_q) frame_count_q <= frame_count_q + 8'd1;
    end
  end
  assign pixel_axis_tready = tready_q;
  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign wr_data           = wr_data_q;
  assign frame_done        = frame_done_q;
  assign frame_count       = frame_count_q;
  assign drop_count        = drop_count_q;
endmodule
